// File: rtl/crc32_frame_engine.sv
// Frame-aware streaming CRC-32 (reflected) over byte-masked beats.
// Produces a registered per-frame CRC, a residue-based FCS-good flag and framing-error pulses.
module crc32_frame_engine #(
  parameter int          INPUT_WIDTH_BYTES = 8,
  parameter logic [31:0] POLY              = 32'hEDB88320,
  parameter logic [31:0] INITIAL_CRC       = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE           = 32'hDEBB20E3
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [INPUT_WIDTH_BYTES*8-1:0] i_data,
  input  logic [INPUT_WIDTH_BYTES-1:0]   i_valid,
  input  logic                           i_first,
  input  logic                           i_last,
  output logic [31:0]                    o_crc,
  output logic                           o_crc_good,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_in_frame
);

  localparam int N = INPUT_WIDTH_BYTES;

  function automatic logic [31:0] table_entry(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'd0, idx};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte-at-a-time lookup table, constant-folded from POLY.
  logic [31:0] crc_table [256];
  for (genvar i = 0; i < 256; i++) begin : g_table
    assign crc_table[i] = table_entry(8'(i));
  end

  logic [31:0] crc_q;
  logic        in_frame_q;
  logic [31:0] crc_out_q;
  logic        good_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] crc_d;
  logic        beat_active;

  assign beat_active = |i_valid;

  // Lane chain: invalid lanes pass the running value through untouched.
  always_comb begin
    crc_d = i_first ? INITIAL_CRC : crc_q;
    for (int k = 0; k < N; k++) begin
      if (i_valid[k]) begin
        crc_d = (crc_d >> 8) ^ crc_table[crc_d[7:0] ^ i_data[8*k +: 8]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_q      <= INITIAL_CRC;
      in_frame_q <= 1'b0;
      crc_out_q  <= 32'd0;
      good_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (beat_active) begin
        if (i_first || in_frame_q) begin
          // A first beat inside an open frame drops the old frame silently apart from err.
          err_q <= i_first && in_frame_q;
          if (i_last) begin
            crc_out_q  <= crc_d ^ 32'hFFFFFFFF;
            good_q     <= (crc_d == RESIDUE);
            done_q     <= 1'b1;
            crc_q      <= INITIAL_CRC;
            in_frame_q <= 1'b0;
          end else begin
            crc_q      <= crc_d;
            in_frame_q <= 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign o_crc      = crc_out_q;
  assign o_crc_good = good_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_in_frame = in_frame_q;

endmodule

// File: doc/crc32_frame_engine.md
Name: crc32_frame_engine

Overview:
Streaming, frame-aware CRC-32 engine for the MAC TX/RX datapaths, with a parametrised data width and polynomial. It accumulates a reflected CRC over byte-masked beats between first/last markers. It produces a registered per-frame result with a done strobe, a residue-based FCS-good flag and a framing-error flag. It serves both as the TX FCS generator (o_crc) and as the RX FCS checker (o_crc_good), and supports back-to-back frames with no idle cycles.

Parameters:
INPUT_WIDTH_BYTES, 8, bytes per beat; lane 0 = i_data[7:0] = earliest byte on the wire.
POLY, 32'hEDB88320, reflected generator polynomial; the 256-entry table is computed at elaboration from POLY, with no memory file.
INITIAL_CRC, 32'hFFFFFFFF, register seed at frame start.
RESIDUE, 32'hDEBB20E3, register value (before output inversion) that indicates a correct trailing FCS.

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_data  input  INPUT_WIDTH_BYTES*8  beat data
i_valid  input  INPUT_WIDTH_BYTES  per-lane byte valid; the beat is active if any bit is set
i_first  input  1  active beat is the first beat of a frame
i_last  input  1  active beat is the last beat of a frame
o_crc  output  32  final CRC of the last completed frame (register ^ 32'hFFFFFFFF)
o_crc_good  output  1  final register == RESIDUE for the last completed frame
o_done  output  1  one-cycle pulse: o_crc and o_crc_good updated
o_err  output  1  one-cycle pulse: framing violation
o_in_frame  output  1  a frame is open (first seen, last not yet seen)

Behaviour:
- Reset (asynchronous assert, synchronous release): crc=INITIAL_CRC, in_frame=0, o_crc=0, o_crc_good=0, o_done=0, o_err=0.
- Per-lane update, lanes 0..N-1 in order: if i_valid[k], s[k+1]=(s[k]>>8)^table[s[k][7:0]^byte k]; otherwise s[k+1]=s[k]. Non-contiguous masks are legal and skip the invalid lanes.
- Chain seed s[0]: INITIAL_CRC if i_first, else the crc register.
- Inactive beat (i_valid==0): no state change. i_first and i_last are ignored. o_done=0 and o_err=0.
- Active beat with i_first=1, in_frame=0: frame starts; crc<=s[N].
- Active beat with i_first=1, in_frame=1: the open frame is aborted without o_done. o_err pulses the next cycle, and the new frame starts from the seed.
- Active beat with i_first=0, in_frame=0: the beat is discarded, crc is unchanged, and o_err pulses the next cycle.
- Active beat with i_first=0, in_frame=1: crc<=s[N].
- Active beat with i_last=1 (frame accepted as above):
  - o_crc<=s[N]^32'hFFFFFFFF and o_crc_good<=(s[N]==RESIDUE); o_done pulses the next cycle (latency 1 from the last beat).
  - crc<=INITIAL_CRC and in_frame<=0.
- i_first and i_last on the same active beat form a single-beat frame: seed used, done next cycle, in_frame stays 0.
- Back-to-back: a last beat followed by a first beat on the next cycle needs no bubble. A last beat and a first beat may not share a cycle, except as a single-beat frame.
- o_crc and o_crc_good hold their values until the next o_done. o_in_frame reflects the registered in_frame.
- The update is single-cycle combinational over N lanes; throughput is one beat per clock.

Test Plan:
1. Beat A = "12345678" (i_data=64'h3837363534333231), i_valid=8'hFF, i_first; beat B = "9" (0x39), i_valid=8'h01, i_last → o_done one cycle after B, o_crc=32'hCBF43926, o_crc_good=0.
2. Beat A as in 1; beat B = 39,26,39,F4,CB in lanes 0-4, i_valid=8'h1F, i_last → o_crc_good=1, o_crc=32'h2144DF1C.
3. Single beat byte 0x00, i_valid=8'h01, i_first+i_last → o_crc=32'hD202EF8D next cycle; o_in_frame stays 0. Repeat this beat with an i_valid=0 cycle between the two, holding i_first/i_last=1 during that cycle → identical second result and no extra o_done.
4. Run scenario 1 with beat A replaced by two half beats (i_valid=8'h0F then 8'hF0 with the data in the upper lanes) → o_crc=32'hCBF43926.
5. Framing errors:
   - Open a frame, then send a new i_first beat before i_last → o_err pulse; the new frame's result matches its own stand-alone CRC.
   - Send an active beat with no open frame → o_err pulse, crc unchanged.
6. Assert i_reset_n low mid-frame → all outputs 0 immediately. After release, run scenario 1 → 32'hCBF43926. Also run scenarios 1 and 2 back-to-back with no bubble → two consecutive o_done pulses with the correct values.
